break_value_engine: RTL and testbench

Multi-candidate, handshaked break-value unit for the WalkSAT flip-selection path. It accepts one broken-clause bit-vector and one validity mask per flip candidate. It counts masked broken clauses for all candidates in parallel, CHUNK clause bits per cycle, then selects the minimum break value and its candidate index. It sits between the clause-evaluator array and the variable-selection logic, replacing the single-candidate, single-cycle counter.

---
 rtl/break_value_engine.sv | 121 ++++++++++++
 tb/tb_break_value_engine.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/break_value_engine.sv
// Multi-candidate break-value unit: counts masked broken clauses per flip candidate,
// CHUNK bits per cycle, then reports every count plus the minimum and its index.
module break_value_engine #(
  parameter int NUM_CANDIDATES = 4,
  parameter int NUM_CLAUSES    = 20,
  parameter int CHUNK          = 8,
  parameter int BV_BITS        = 5,
  parameter int IDX_BITS       = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_CANDIDATES*NUM_CLAUSES-1:0] is_broken,
  input  logic [NUM_CANDIDATES*NUM_CLAUSES-1:0] mask,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_CANDIDATES*BV_BITS-1:0]   break_values,
  output logic [BV_BITS-1:0]                  min_value,
  output logic [IDX_BITS-1:0]                 min_index,
  output logic                                zero_break
);

  localparam int NUM_CHUNKS = (NUM_CLAUSES + CHUNK - 1) / CHUNK;
  localparam int PAD_W      = NUM_CHUNKS * CHUNK;
  localparam int CNT_BITS   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_CHUNK = CNT_BITS'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, COUNT, MIN, OUT} state_t;

  state_t              state;
  logic [PAD_W-1:0]    pending   [NUM_CANDIDATES];
  logic [BV_BITS-1:0]  acc       [NUM_CANDIDATES];
  logic [BV_BITS-1:0]  chunk_pop [NUM_CANDIDATES];
  logic [CNT_BITS-1:0] chunk_cnt;
  logic [BV_BITS-1:0]  best_value;
  logic [IDX_BITS-1:0] best_index;

  assign in_ready = (state == IDLE) && !reset;

  // Each candidate's pending bits shift down one chunk per cycle, so the chunk being
  // counted is always the low CHUNK bits; the zero padding above NUM_CLAUSES adds nothing.
  always_comb begin
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      chunk_pop[i] = '0;
      for (int b = 0; b < CHUNK; b++) begin
        chunk_pop[i] = chunk_pop[i] + BV_BITS'(pending[i][b]);
      end
    end
  end

  // Strict less-than keeps the earliest candidate on ties.
  always_comb begin
    best_value = acc[0];
    best_index = '0;
    for (int i = 1; i < NUM_CANDIDATES; i++) begin
      if (acc[i] < best_value) begin
        best_value = acc[i];
        best_index = IDX_BITS'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      chunk_cnt    <= '0;
      out_valid    <= 1'b0;
      break_values <= '0;
      min_value    <= '0;
      min_index    <= '0;
      zero_break   <= 1'b0;
      for (int i = 0; i < NUM_CANDIDATES; i++) begin
        acc[i]     <= '0;
        pending[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_CANDIDATES; i++) begin
              pending[i] <= PAD_W'(is_broken[i*NUM_CLAUSES +: NUM_CLAUSES] &
                                   mask[i*NUM_CLAUSES +: NUM_CLAUSES]);
              acc[i]     <= '0;
            end
            chunk_cnt <= '0;
            state     <= COUNT;
          end
        end
        COUNT: begin
          for (int i = 0; i < NUM_CANDIDATES; i++) begin
            acc[i]     <= acc[i] + chunk_pop[i];
            pending[i] <= pending[i] >> CHUNK;
          end
          chunk_cnt <= chunk_cnt + CNT_BITS'(1);
          if (chunk_cnt == LAST_CHUNK) begin
            state <= MIN;
          end
        end
        MIN: begin
          for (int i = 0; i < NUM_CANDIDATES; i++) begin
            break_values[i*BV_BITS +: BV_BITS] <= acc[i];
          end
          min_value  <= best_value;
          min_index  <= best_index;
          zero_break <= (best_value == '0);
          out_valid  <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_break_value_engine.sv
// Directed bench for break_value_engine: default instance plus three parameter variants.
module tb_break_value_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, zero_break;
  logic [79:0] is_broken, mask;
  logic [19:0] break_values;
  logic [4:0]  min_value;
  logic [1:0]  min_index;

  logic        aux_ready;
  logic        in_valid_b, in_ready_b, out_valid_b, zero_break_b;
  logic [15:0] is_broken_b, mask_b;
  logic [7:0]  bv_b;
  logic [3:0]  min_value_b;
  logic [0:0]  min_index_b;

  logic        in_valid_c, in_ready_c, out_valid_c, zero_break_c;
  logic [33:0] is_broken_c, mask_c;
  logic [9:0]  bv_c;
  logic [4:0]  min_value_c;
  logic [0:0]  min_index_c;

  logic        in_valid_d, in_ready_d, out_valid_d, zero_break_d;
  logic [19:0] is_broken_d, mask_d;
  logic [4:0]  bv_d;
  logic [4:0]  min_value_d;
  logic [0:0]  min_index_d;

  int checks = 0;
  int errors = 0;

  localparam logic [79:0] BASIC_BROKEN = {20'hABCDE, 20'h80001, 20'h00005, 20'hFFFFF};
  localparam logic [79:0] BASIC_MASK   = {20'h00000, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF};
  localparam logic [19:0] BASIC_BV     = {5'd0, 5'd2, 5'd2, 5'd20};
  localparam logic [79:0] TIE_BROKEN   = {20'h1F000, 20'h40000, 20'hF0001, 20'h00007};
  localparam logic [79:0] TIE_MASK     = {20'hFFFFF, 20'hFFFFF, 20'h0000F, 20'hFFFFF};
  localparam logic [19:0] TIE_BV       = {5'd5, 5'd1, 5'd1, 5'd3};

  break_value_engine dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .is_broken(is_broken), .mask(mask), .out_valid(out_valid), .out_ready(out_ready),
    .break_values(break_values), .min_value(min_value), .min_index(min_index),
    .zero_break(zero_break)
  );

  break_value_engine #(.NUM_CANDIDATES(2), .NUM_CLAUSES(8), .CHUNK(8), .BV_BITS(4), .IDX_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .is_broken(is_broken_b), .mask(mask_b), .out_valid(out_valid_b), .out_ready(aux_ready),
    .break_values(bv_b), .min_value(min_value_b), .min_index(min_index_b),
    .zero_break(zero_break_b)
  );

  break_value_engine #(.NUM_CANDIDATES(2), .NUM_CLAUSES(17), .CHUNK(4), .BV_BITS(5), .IDX_BITS(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .is_broken(is_broken_c), .mask(mask_c), .out_valid(out_valid_c), .out_ready(aux_ready),
    .break_values(bv_c), .min_value(min_value_c), .min_index(min_index_c),
    .zero_break(zero_break_c)
  );

  break_value_engine #(.NUM_CANDIDATES(1), .NUM_CLAUSES(20), .CHUNK(8), .BV_BITS(5), .IDX_BITS(1)) dut_d (
    .clk(clk), .reset(reset), .in_valid(in_valid_d), .in_ready(in_ready_d),
    .is_broken(is_broken_d), .mask(mask_d), .out_valid(out_valid_d), .out_ready(aux_ready),
    .break_values(bv_d), .min_value(min_value_d), .min_index(min_index_d),
    .zero_break(zero_break_d)
  );

  // Presents one transaction to the default instance and returns cycles until out_valid.
  task automatic drive_main(input logic [79:0] b, input logic [79:0] m, output int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    is_broken = b;
    mask      = m;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    is_broken = BASIC_BROKEN;
    mask = BASIC_MASK;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++;
      if ({out_valid, break_values, min_value, min_index, zero_break} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got %h expected 0", {out_valid, break_values, min_value, min_index, zero_break});
      end
    end
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready); end
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_nothing_accepted: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    drive_main(BASIC_BROKEN, BASIC_MASK, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 4", lat); end
    checks++;
    if (break_values !== BASIC_BV) begin errors++; $display("[TB] FAIL basic_values: got %h expected %h", break_values, BASIC_BV); end
    checks++;
    if ({min_value, min_index, zero_break} !== {5'd0, 2'd3, 1'b1}) begin
      errors++;
      $display("[TB] FAIL basic_min: got %0d/%0d/%b expected 0/3/1", min_value, min_index, zero_break);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL basic_handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_tie_and_mask();
    int lat;
    out_ready = 1'b1;
    drive_main(TIE_BROKEN, TIE_MASK, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL tie_latency: got %0d expected 4", lat); end
    checks++;
    if (break_values !== TIE_BV) begin errors++; $display("[TB] FAIL tie_values: got %h expected %h", break_values, TIE_BV); end
    checks++;
    if ({min_value, min_index, zero_break} !== {5'd1, 2'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL tie_min: got %0d/%0d/%b expected 1/1/0", min_value, min_index, zero_break);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, break_values, min_value, min_index} !== {1'b0, TIE_BV, 5'd1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL tie_held_after_handshake: got %h/%0d/%0d expected %h/1/1", break_values, min_value, min_index, TIE_BV);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b0;
    drive_main(BASIC_BROKEN, BASIC_MASK, lat);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_valid: got %b expected 1", out_valid); end
    in_valid = 1'b1;
    is_broken = TIE_BROKEN;
    mask = TIE_MASK;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, break_values, min_value, min_index, zero_break} !==
          {1'b1, 1'b0, BASIC_BV, 5'd0, 2'd3, 1'b1}) begin
        errors++;
        $display("[TB] FAIL bp_hold: got v=%b r=%b bv=%h min=%0d idx=%0d expected v=1 r=0 bv=%h min=0 idx=3",
                 out_valid, in_ready, break_values, min_value, min_index, BASIC_BV);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL bp_second_latency: got %0d expected 4", lat); end
    checks++;
    if ({break_values, min_value, min_index} !== {TIE_BV, 5'd1, 2'd1}) begin
      errors++;
      $display("[TB] FAIL bp_second_result: got %h/%0d/%0d expected %h/1/1", break_values, min_value, min_index, TIE_BV);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_count();
    int lat;
    out_ready = 1'b1;
    @(negedge clk);
    is_broken = BASIC_BROKEN;
    mask = BASIC_MASK;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if ({out_valid, break_values, min_value, min_index, zero_break} !== '0) begin
        errors++;
        $display("[TB] FAIL midreset_quiet: got %h expected 0", {out_valid, break_values, min_value, min_index, zero_break});
      end
    end
    drive_main(TIE_BROKEN, TIE_MASK, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL midreset_latency: got %0d expected 4", lat); end
    checks++;
    if ({break_values, min_value, min_index, zero_break} !== {TIE_BV, 5'd1, 2'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midreset_result: got %h/%0d/%0d expected %h/1/1", break_values, min_value, min_index, TIE_BV);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep_single_chunk();
    int lat = 0;
    @(negedge clk);
    is_broken_b = {8'h0F, 8'hFF};
    mask_b      = {8'h3C, 8'hFF};
    in_valid_b  = 1'b1;
    @(negedge clk);
    in_valid_b = 1'b0;
    while (!out_valid_b && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2) begin errors++; $display("[TB] FAIL sweep8_latency: got %0d expected 2", lat); end
    checks++;
    if ({bv_b, min_value_b, min_index_b, zero_break_b} !== {4'd2, 4'd8, 4'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sweep8_result: got bv=%h min=%0d idx=%0d expected bv=28 min=2 idx=1", bv_b, min_value_b, min_index_b);
    end
  endtask

  task automatic test_sweep_tail_padding();
    int lat = 0;
    @(negedge clk);
    is_broken_c = '1;
    mask_c      = '1;
    in_valid_c  = 1'b1;
    @(negedge clk);
    in_valid_c = 1'b0;
    while (!out_valid_c && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 6) begin errors++; $display("[TB] FAIL sweep17_latency: got %0d expected 6", lat); end
    checks++;
    if ({bv_c, min_value_c, min_index_c, zero_break_c} !== {5'd17, 5'd17, 5'd17, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sweep17_result: got bv=%h min=%0d idx=%0d expected 17,17 min=17 idx=0", bv_c, min_value_c, min_index_c);
    end
  endtask

  task automatic test_single_candidate();
    int lat = 0;
    @(negedge clk);
    is_broken_d = 20'h00F0F;
    mask_d      = 20'hFFFFF;
    in_valid_d  = 1'b1;
    @(negedge clk);
    in_valid_d = 1'b0;
    while (!out_valid_d && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 4) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 4", lat); end
    checks++;
    if ({bv_d, min_value_d, min_index_d, zero_break_d} !== {5'd8, 5'd8, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_result: got bv=%0d min=%0d idx=%0d expected 8/8/0", bv_d, min_value_d, min_index_d);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    aux_ready = 1'b1;
    in_valid_b = 1'b0; is_broken_b = '0; mask_b = '0;
    in_valid_c = 1'b0; is_broken_c = '0; mask_c = '0;
    in_valid_d = 1'b0; is_broken_d = '0; mask_d = '0;
    test_reset();
    test_basic();
    test_tie_and_mask();
    test_back_to_back();
    test_reset_mid_count();
    test_sweep_single_chunk();
    test_sweep_tail_padding();
    test_single_candidate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
